// File: rtl/jt74259_ser_pkg.sv
// Shared definitions for the 74x259 serial writer: FSM state encodings and counter width.
package jt74259_ser_pkg;
  localparam int CNTW = 4;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    CLR    = 3'd1,
    IDLE   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5,
    CLRP   = 3'd6,
    SETTLE = 3'd7
  } state_e;
endpackage

// File: rtl/jt74259_ser_nxt.sv
// Priority finder: lowest bit index >= start_i where data_i differs from shadow_i.
module jt74259_ser_nxt (
  input  logic [7:0] data_i,
  input  logic [7:0] shadow_i,
  input  logic [2:0] start_i,
  output logic [2:0] idx_o,
  output logic       found_o
);
  logic [7:0] diff;

  always_comb begin
    diff    = data_i ^ shadow_i;
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int n = 7; n >= 0; n--) begin
      if (diff[n] && (3'(n) >= start_i)) begin
        idx_o   = 3'(n);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jt74259_ser.sv
// Writer end of a 74x259 addressable latch link (D/A/LE_b/MR_b), one bit per setup/strobe/hold.
// Define JT74259_SER_DIFF_EN to keep a shadow of the remote latch and skip bits that already match.
module jt74259_ser
  import jt74259_ser_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input  logic       clk,
  input  logic       cl_b,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       clr_req,
  output logic       busy,
  output logic       done,
  output logic       D,
  output logic [2:0] A,
  output logic       LE_b,
  output logic       MR_b
);
  localparam logic [CNTW-1:0] SET_LD = CNTW'(SETUP_CYC - 1);
  localparam logic [CNTW-1:0] STB_LD = CNTW'(STROBE_CYC - 1);

  state_e          st_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      idx_q, a_q;
  logic [7:0]      byte_q;
  logic            d_q, le_b_q, mr_b_q, done_q;
  logic [2:0]      nx_idx;
  logic            nx_found;

`ifdef JT74259_SER_DIFF_EN
  logic [7:0] shadow_q, nx_data;
  logic [2:0] nx_start;
  logic       nx_hit;

  assign nx_data  = (st_q == IDLE) ? din : byte_q;
  assign nx_start = (st_q == IDLE) ? 3'd0 : idx_q + 3'd1;

  jt74259_ser_nxt u_nxt (
    .data_i  (nx_data),
    .shadow_i(shadow_q),
    .start_i (nx_start),
    .idx_o   (nx_idx),
    .found_o (nx_hit)
  );

  // start index wraps after bit 7, so the last bit always ends the transfer
  assign nx_found = nx_hit && !((st_q != IDLE) && (idx_q == 3'd7));

  always_ff @(posedge clk or negedge cl_b) begin
    if (!cl_b)                                          shadow_q <= '0;
    else if (st_q == RST || st_q == CLR || st_q == CLRP) shadow_q <= '0;
    else if (st_q == STROBE && cnt_q == '0)             shadow_q[idx_q] <= d_q;
  end
`else
  assign nx_idx   = (st_q == IDLE) ? 3'd0 : idx_q + 3'd1;
  assign nx_found = (st_q == IDLE) || (idx_q != 3'd7);
`endif

  always_ff @(posedge clk or negedge cl_b) begin
    if (!cl_b) begin
      st_q   <= RST;
      cnt_q  <= '0;
      idx_q  <= '0;
      byte_q <= '0;
      a_q    <= '0;
      d_q    <= 1'b0;
      le_b_q <= 1'b1;
      mr_b_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        RST: st_q <= CLR;
        CLR: begin
          st_q   <= IDLE;
          mr_b_q <= 1'b1;
        end
        IDLE: begin
          if (clr_req) begin
            st_q   <= CLRP;
            mr_b_q <= 1'b0;
            cnt_q  <= STB_LD;
          end else if (din_valid) begin
            byte_q <= din;
            if (nx_found) begin
              st_q  <= SETUP;
              idx_q <= nx_idx;
              a_q   <= nx_idx;
              d_q   <= din[nx_idx];
              cnt_q <= SET_LD;
            end else begin
              st_q <= SETTLE;
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            st_q   <= STROBE;
            le_b_q <= 1'b0;
            cnt_q  <= STB_LD;
          end else cnt_q <= cnt_q - CNTW'(1);
        end
        STROBE: begin
          if (cnt_q == '0) begin
            st_q   <= HOLD;
            le_b_q <= 1'b1;
          end else cnt_q <= cnt_q - CNTW'(1);
        end
        HOLD: begin
          if (nx_found) begin
            st_q  <= SETUP;
            idx_q <= nx_idx;
            a_q   <= nx_idx;
            d_q   <= byte_q[nx_idx];
            cnt_q <= SET_LD;
          end else begin
            st_q   <= IDLE;
            done_q <= 1'b1;
          end
        end
        CLRP: begin
          if (cnt_q == '0) begin
            st_q   <= IDLE;
            mr_b_q <= 1'b1;
            done_q <= 1'b1;
          end else cnt_q <= cnt_q - CNTW'(1);
        end
        SETTLE: begin
          st_q   <= IDLE;
          done_q <= 1'b1;
        end
        default: st_q <= RST;
      endcase
    end
  end

  assign din_ready = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign done      = done_q;
  assign D         = d_q;
  assign A         = a_q;
  assign LE_b      = le_b_q;
  assign MR_b      = mr_b_q;
endmodule

// File: tb/tb_jt74259_ser.sv
// Scoreboard bench for jt74259_ser: dut0 uses default timing, dut1 uses SETUP_CYC=3/STROBE_CYC=2.
module tb_jt74259_ser;
  localparam int S_MR = 0, S_LE = 1, S_RDY = 2, S_BUSY = 3, S_Q = 4;

  typedef struct { int dut; int a; int d; int w; int su; } sev_t;
  typedef struct { int dut; int cyc; } dev_t;
  typedef struct { int cyc; int dut; int sel; int exp; } chk_t;

  logic       clk = 1'b0;
  logic       cl_b;
  logic [7:0] din [2];
  logic       vld [2], clr [2];
  logic       rdy [2], busy [2], done [2], d [2], le_b [2], mr_b [2];
  logic [2:0] a [2];

  sev_t exp_q[$];
  dev_t done_q[$];
  chk_t chk_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  bit   fin = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jt74259_ser #(.SETUP_CYC(1), .STROBE_CYC(1)) u_dut0 (
    .clk(clk), .cl_b(cl_b), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
    .clr_req(clr[0]), .busy(busy[0]), .done(done[0]), .D(d[0]), .A(a[0]),
    .LE_b(le_b[0]), .MR_b(mr_b[0])
  );

  jt74259_ser #(.SETUP_CYC(3), .STROBE_CYC(2)) u_dut1 (
    .clk(clk), .cl_b(cl_b), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
    .clr_req(clr[1]), .busy(busy[1]), .done(done[1]), .D(d[1]), .A(a[1]),
    .LE_b(le_b[1]), .MR_b(mr_b[1])
  );

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] q [2];
  int prev_le [2], stab [2], wid [2], sa [2], sd [2], ssu [2], moved [2], pa [2], pd [2];

  function automatic string sname(int sel);
    case (sel)
      S_MR:    return "MR_b";
      S_LE:    return "LE_b";
      S_RDY:   return "din_ready";
      S_BUSY:  return "busy";
      default: return "latch_Q";
    endcase
  endfunction

  function automatic int act(int k, int sel);
    case (sel)
      S_MR:    return int'(mr_b[k]);
      S_LE:    return int'(le_b[k]);
      S_RDY:   return int'(rdy[k]);
      S_BUSY:  return int'(busy[k]);
      default: return int'(q[k]);
    endcase
  endfunction

  function automatic void cmp(string nm, int k, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, k, cyc, got, want);
    end
  endfunction

  initial begin
    sev_t e;
    dev_t de;
    chk_t c;
    for (int k = 0; k < 2; k++) begin
      q[k] = '0; prev_le[k] = 1; stab[k] = 0; wid[k] = 0; sa[k] = 0; sd[k] = 0;
      ssu[k] = 0; moved[k] = 0; pa[k] = 0; pd[k] = 0;
    end
    forever begin
      @(negedge clk);
      // behavioural 74x259: MR_b clears, LE_b low makes Q[A] follow D
      for (int k = 0; k < 2; k++) begin
        if (!mr_b[k])     q[k] = '0;
        else if (!le_b[k]) q[k][a[k]] = d[k];
      end
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        if (c.cyc < cyc) cmp("chk_late", c.dut, cyc, c.cyc);
        else             cmp(sname(c.sel), c.dut, act(c.dut, c.sel), c.exp);
      end
      for (int k = 0; k < 2; k++) begin
        if (!le_b[k]) begin
          if (prev_le[k] != 0) begin
            sa[k] = int'(a[k]); sd[k] = int'(d[k]); ssu[k] = stab[k]; wid[k] = 1; moved[k] = 0;
          end else begin
            wid[k]++;
            if (int'(a[k]) != sa[k] || int'(d[k]) != sd[k]) moved[k] = 1;
          end
        end else begin
          if (prev_le[k] == 0) begin
            if (exp_q.size() == 0) cmp("strobe_unexpected", k, sa[k], -1);
            else begin
              e = exp_q.pop_front();
              cmp("strobe_dut", k, k, e.dut);
              cmp("strobe_A", k, sa[k], e.a);
              cmp("strobe_D", k, sd[k], e.d);
              cmp("strobe_width", k, wid[k], e.w);
              cmp("strobe_AD_moved", k, moved[k], 0);
              n_cmp++;
              if (ssu[k] < e.su) begin
                n_err++;
                $display("FAIL strobe_setup dut%0d cyc %0d: got %0d want >=%0d", k, cyc, ssu[k], e.su);
              end
            end
          end
          if (int'(a[k]) == pa[k] && int'(d[k]) == pd[k]) stab[k]++;
          else stab[k] = 1;
        end
        pa[k] = int'(a[k]); pd[k] = int'(d[k]); prev_le[k] = int'(le_b[k]);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        de = done_q.pop_front();
        cmp("done_missing", de.dut, cyc, de.cyc);
      end
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          if (done_q.size() == 0) cmp("done_unexpected", k, cyc, -1);
          else begin
            de = done_q.pop_front();
            cmp("done_dut", k, k, de.dut);
            cmp("done_cycle", k, cyc, de.cyc);
          end
        end
      end
      if (fin || cyc > 5000) begin
        cmp("run_finished", 0, int'(fin), 1);
        cmp("strobes_left", 0, exp_q.size(), 0);
        cmp("dones_left", 0, done_q.size(), 0);
        cmp("checks_left", 0, chk_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int k, int sel, int want, int off);
    chk_t c;
    c.cyc = cyc + off; c.dut = k; c.sel = sel; c.exp = want;
    chk_q.push_back(c);
  endtask

  task automatic pstr(int k, int ai, int di);
    sev_t e;
    e.dut = k; e.a = ai; e.d = di;
    e.w  = (k == 0) ? 1 : 2;
    e.su = (k == 0) ? 1 : 3;
    exp_q.push_back(e);
  endtask

  task automatic pall(int k, logic [7:0] b);
    for (int i = 0; i < 8; i++) pstr(k, i, int'(b[i]));
  endtask

  // Offer one byte; done expected lat cycles after the accept edge.
  task automatic wr(int k, logic [7:0] b, int lat, logic [7:0] qx);
    int   acc;
    dev_t de;
    chk(k, S_RDY, 1, 0);
    din[k] = b; vld[k] = 1'b1;
    tick();
    acc = cyc; vld[k] = 1'b0;
    de.dut = k; de.cyc = acc + lat;
    done_q.push_back(de);
    chk(k, S_RDY, 0, 0);
    chk(k, S_BUSY, 1, 0);
    repeat (lat + 1) tick();
    chk(k, S_Q, int'(qx), 0);
    chk(k, S_BUSY, 0, 0);
  endtask

  initial begin
    int   c0, r;
    dev_t de;
    cl_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[k] = '0; vld[k] = 1'b0; clr[k] = 1'b0;
    end
    // reset state, then release
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk(k, S_MR, 0, 0); chk(k, S_LE, 1, 0); chk(k, S_RDY, 0, 0); chk(k, S_BUSY, 1, 0);
    end
    repeat (3) tick();
    cl_b = 1'b1;
    for (int off = 0; off < 3; off++)
      for (int k = 0; k < 2; k++) begin
        chk(k, S_MR, (off == 2) ? 1 : 0, off);
        chk(k, S_RDY, (off == 2) ? 1 : 0, off);
      end
    repeat (2) tick();

    // main writes on dut0
`ifdef JT74259_SER_DIFF_EN
    pstr(0, 0, 1); pstr(0, 7, 1);
    wr(0, 8'h81, 6, 8'h81);
    pstr(0, 1, 1);
    wr(0, 8'h83, 3, 8'h83);
    wr(0, 8'h83, 1, 8'h83);          // matches shadow: SETTLE only
`else
    pall(0, 8'hA5);
    wr(0, 8'hA5, 24, 8'hA5);
`endif

    // clr_req beats din_valid
    din[0] = 8'hFF; vld[0] = 1'b1; clr[0] = 1'b1;
    chk(0, S_RDY, 1, 0);
    tick();
    c0 = cyc; vld[0] = 1'b0; clr[0] = 1'b0;
    de.dut = 0; de.cyc = c0 + 1;
    done_q.push_back(de);
    chk(0, S_MR, 0, 0); chk(0, S_RDY, 0, 0);
    chk(0, S_MR, 1, 1); chk(0, S_RDY, 1, 1); chk(0, S_Q, 0, 1);
    chk(0, S_BUSY, 0, 2);
    repeat (3) tick();

    // slow-timing instance
`ifdef JT74259_SER_DIFF_EN
    for (int i = 0; i < 4; i++) pstr(1, i, 1);
    wr(1, 8'h0F, 24, 8'h0F);
`else
    pall(1, 8'h0F);
    wr(1, 8'h0F, 48, 8'h0F);
`endif

    // abort during bit 3 STROBE (accept edge + 10 with default timing)
    pstr(0, 0, 1); pstr(0, 1, 1); pstr(0, 2, 1);
    chk(0, S_RDY, 1, 0);
    din[0] = 8'hFF; vld[0] = 1'b1;
    tick();
    c0 = cyc; vld[0] = 1'b0;
    while (cyc < c0 + 10) tick();
    cl_b = 1'b0;
    chk(0, S_LE, 1, 0); chk(0, S_MR, 0, 0); chk(0, S_BUSY, 1, 0); chk(0, S_RDY, 0, 0);
    chk(1, S_MR, 0, 0);
    chk(0, S_Q, 0, 1);
    repeat (2) tick();
    cl_b = 1'b1;
    r = cyc;
    chk(0, S_MR, 0, 1);
    chk(0, S_RDY, 1, 2);
    repeat (3) tick();

    // next byte after abort is accepted normally
`ifdef JT74259_SER_DIFF_EN
    for (int i = 2; i < 6; i++) pstr(0, i, 1);
    wr(0, 8'h3C, 12, 8'h3C);
`else
    pall(0, 8'h3C);
    wr(0, 8'h3C, 24, 8'h3C);
`endif
    repeat (3) tick();
    if (r < 0) tick();
    fin = 1'b1;
  end
endmodule
